// File: rtl/hs_pipe_sub.sv
// Pipelined WIDTH-bit subtractor, CHUNK bits of ripple borrow per stage, valid/ready handshake.
// Define HS_PIPE_SUB_OVF_EN to add the registered signed-overflow output Ov.
module hs_pipe_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Df,
  output logic             Bo,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HS_PIPE_SUB_OVF_EN
  ,
  output logic             Ov
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Stage registers: operands travel whole, df collects finished low chunks.
  logic             valid_reg  [STAGES];
  logic [WIDTH-1:0] a_reg      [STAGES];
  logic [WIDTH-1:0] b_reg      [STAGES];
  logic [WIDTH-1:0] df_reg     [STAGES];
  logic             borrow_reg [STAGES];

  // Per-stage view of the token entering it and the chunk it resolves.
  logic             valid_cur  [STAGES];
  logic [WIDTH-1:0] a_cur      [STAGES];
  logic [WIDTH-1:0] b_cur      [STAGES];
  logic [WIDTH-1:0] df_cur     [STAGES];
  logic             borrow_cur [STAGES];
  logic [CHUNK:0]   diff       [STAGES];
  logic [WIDTH-1:0] df_next    [STAGES];

  logic en;

  // A held result freezes every stage, so nothing can be overwritten.
  assign en       = rst_n & (~out_valid | out_ready);
  assign in_ready = en;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_cur[gi]  = in_valid;
        assign a_cur[gi]      = A;
        assign b_cur[gi]      = B;
        assign df_cur[gi]     = '0;
        assign borrow_cur[gi] = Bi;
      end else begin : g_body
        assign valid_cur[gi]  = valid_reg[gi-1];
        assign a_cur[gi]      = a_reg[gi-1];
        assign b_cur[gi]      = b_reg[gi-1];
        assign df_cur[gi]     = df_reg[gi-1];
        assign borrow_cur[gi] = borrow_reg[gi-1];
      end

      // Bit CHUNK of the extended difference is the borrow out of this chunk.
      assign diff[gi] = {1'b0, a_cur[gi][gi*CHUNK +: CHUNK]}
                      - {1'b0, b_cur[gi][gi*CHUNK +: CHUNK]}
                      - {{CHUNK{1'b0}}, borrow_cur[gi]};
      assign df_next[gi] = df_cur[gi] | (WIDTH'(diff[gi][CHUNK-1:0]) << (gi*CHUNK));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s]  <= 1'b0;
        a_reg[s]      <= '0;
        b_reg[s]      <= '0;
        df_reg[s]     <= '0;
        borrow_reg[s] <= 1'b0;
      end
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s]  <= valid_cur[s];
        a_reg[s]      <= a_cur[s];
        b_reg[s]      <= b_cur[s];
        df_reg[s]     <= df_next[s];
        borrow_reg[s] <= diff[s][CHUNK];
      end
    end
  end

  assign out_valid = valid_reg[LAST];
  assign Df        = df_reg[LAST];
  assign Bo        = borrow_reg[LAST];

`ifdef HS_PIPE_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Ov <= 1'b0;
    end else if (en) begin
      Ov <= (a_cur[LAST][WIDTH-1] ^ b_cur[LAST][WIDTH-1])
          & (df_next[LAST][WIDTH-1] ^ a_cur[LAST][WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_hs_pipe_sub.sv
// Directed self-checking bench for hs_pipe_sub with WIDTH=8, CHUNK=4 (two stages).
// Exercises Ov as well when HS_PIPE_SUB_OVF_EN is defined.
module tb_hs_pipe_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bi;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Df;
  logic       Bo;
  logic       out_valid;
  logic       out_ready;
`ifdef HS_PIPE_SUB_OVF_EN
  logic       Ov;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hs_pipe_sub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Bi        (Bi),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Df        (Df),
    .Bo        (Bo),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef HS_PIPE_SUB_OVF_EN
    ,
    .Ov        (Ov)
`endif
  );

  always #5 clk = ~clk;

  // Sample and drive 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; Bi = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (Df !== 8'h00) begin n_fail++; $display("FAIL reset_df got=%h exp=00", Df); end
    n_checks++;
    if (Bo !== 1'b0) begin n_fail++; $display("FAIL reset_bo got=%b exp=0", Bo); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    tick();
    $display("reset: out_valid=%b Df=%h Bo=%b", out_valid, Df, Bo);
  endtask

  // One isolated transfer: invisible after the accept edge, visible after the next.
  task automatic test_single(input logic [7:0] a, input logic [7:0] b, input logic bi,
                             input logic [7:0] exp_df, input logic exp_bo);
    out_ready = 1'b1;
    A = a; B = b; Bi = bi; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_checks++;
    if (Df !== exp_df) begin n_fail++; $display("FAIL single_df a=%h b=%h bi=%b got=%h exp=%h", a, b, bi, Df, exp_df); end
    n_checks++;
    if (Bo !== exp_bo) begin n_fail++; $display("FAIL single_bo a=%h b=%h bi=%b got=%b exp=%b", a, b, bi, Bo, exp_bo); end
    $display("single: %h - %h - %b -> Df=%h Bo=%b", a, b, bi, Df, Bo);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    va[0] = 8'h10; vb[0] = 8'h01; vd[0] = 8'h0F;
    va[1] = 8'h20; vb[1] = 8'h02; vd[1] = 8'h1E;
    va[2] = 8'h30; vb[2] = 8'h03; vd[2] = 8'h2D;
    out_ready = 1'b1; Bi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        A = va[i]; B = vb[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || Df !== vd[i-1] || Bo !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_result%0d got v=%b Df=%h Bo=%b exp v=1 Df=%h Bo=0", i-1, out_valid, Df, Bo, vd[i-1]);
        end
        $display("b2b: result %0d Df=%h Bo=%b", i-1, Df, Bo);
      end
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1; Bi = 1'b0;
    A = 8'h10; B = 8'h01; in_valid = 1'b1;
    tick();
    A = 8'h20; B = 8'h02;
    tick();
    // First result now presented; consumer stalls while the third token waits.
    out_ready = 1'b0;
    A = 8'h30; B = 8'h03;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || Df !== 8'h0F) begin
        n_fail++;
        $display("FAIL stall_hold%0d got rdy=%b v=%b Df=%h exp rdy=0 v=1 Df=0f", i, in_ready, out_valid, Df);
      end
      $display("stall: cycle %0d in_ready=%b Df=%h", i, in_ready, Df);
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || Df !== 8'h1E) begin
      n_fail++; $display("FAIL stall_result1 got v=%b Df=%h exp v=1 Df=1e", out_valid, Df);
    end
    $display("stall: result 1 Df=%h", Df);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || Df !== 8'h2D) begin
      n_fail++; $display("FAIL stall_result2 got v=%b Df=%h exp v=1 Df=2d", out_valid, Df);
    end
    $display("stall: result 2 Df=%h", Df);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; Bi = 1'b0;
    A = 8'h35; B = 8'h12; in_valid = 1'b1;
    tick();
    A = 8'h12; B = 8'h35;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || Df !== 8'h00 || Bo !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear got v=%b Df=%h Bo=%b exp v=0 Df=00 Bo=0", out_valid, Df, Bo);
    end
    $display("midreset: out_valid=%b Df=%h Bo=%b", out_valid, Df, Bo);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale%0d got=%b exp=0", i, out_valid); end
    end
  endtask

`ifdef HS_PIPE_SUB_OVF_EN
  task automatic test_ovf(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_df, input logic exp_bo, input logic exp_ov);
    out_ready = 1'b1; Bi = 1'b0;
    A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || Df !== exp_df || Bo !== exp_bo || Ov !== exp_ov) begin
      n_fail++;
      $display("FAIL ovf a=%h b=%h got v=%b Df=%h Bo=%b Ov=%b exp v=1 Df=%h Bo=%b Ov=%b",
               a, b, out_valid, Df, Bo, Ov, exp_df, exp_bo, exp_ov);
    end
    $display("ovf: %h - %h -> Df=%h Bo=%b Ov=%b", a, b, Df, Bo, Ov);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    test_single(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1);
    test_single(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    test_single(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0);
    test_single(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    test_single(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef HS_PIPE_SUB_OVF_EN
    test_ovf(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    test_ovf(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_pipe_sub.md
Name: hs_pipe_sub

Overview:
- Parametrised, pipelined N-bit subtractor; next generation of the 1-bit half subtractor (A, B -> Df, Bo).
- Adds WIDTH-bit operands, a borrow-in input for multi-word chaining, and ripple-borrow split into CHUNK-bit pipeline stages.
- Valid/ready handshake on input and output; the whole pipeline stalls under back-pressure.
- Used as the arithmetic datapath element in sequenced ALU and accumulator blocks.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
A  input  WIDTH  minuend, unsigned
B  input  WIDTH  subtrahend, unsigned
Bi  input  1  borrow-in, subtracted at bit 0
in_valid  input  1  A/B/Bi valid this cycle
in_ready  output  1  block accepts input this cycle
Df  output  WIDTH  difference, (A - B - Bi) mod 2^WIDTH
Bo  output  1  borrow-out; 1 iff A < B + Bi (unsigned)
out_valid  output  1  Df/Bo valid
out_ready  input  1  consumer accepts result this cycle

Behaviour:
- Reset:
  - rst_n sampled low at an edge: out_valid=0, Df=0, Bo=0.
  - All internal stage valid bits and data registers are cleared to 0.
  - in_ready=0 while rst_n is low.
- Global enable: en = rst_n & (~out_valid | out_ready). in_ready = en (combinational from out_valid/out_ready).
- Accept:
  - Input transfer occurs when in_valid & in_ready.
  - Stage-0 valid loads in_valid & en. With in_valid=0 and en=1, a bubble enters.
- Stage k (0..STAGES-1):
  - Computes Df[k*CHUNK +: CHUNK] and the chunk borrow from A/B chunk k and the borrow of stage k-1. Stage 0 uses Bi.
  - Unprocessed upper A/B chunks and already-computed lower Df chunks travel with the token in stage registers (skew/deskew).
- Last stage drives Df, Bo and out_valid directly from registers. No combinational path from A/B to outputs.
- Latency:
  - An input accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. it is visible for the first time in the cycle following edge t+STAGES-1.
  - With STAGES=1 the result is visible the cycle after acceptance.
  - Throughput is 1 result per cycle while out_ready=1.
- Stall:
  - When en=0, every stage register, including outputs, holds its value.
  - No token is dropped or duplicated, and order is preserved.
- Output transfer occurs on out_valid & out_ready. If no new token arrives, out_valid falls at the next edge.
- Simultaneous output transfer and input accept in the same cycle is legal; en=1.
- Df/Bo are held stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed. A stalled output blocks all stages.
- Boundaries:
  - A=B, Bi=0 -> Df=0, Bo=0.
  - A=0, B=0, Bi=1 -> Df=all ones, Bo=1.
  - A=0, B=all ones, Bi=1 -> Df=0, Bo=1.
- Reset mid-flight discards all in-flight tokens. out_valid=0 in the cycle after the reset edge.

Optional Feature:
- Macro HS_PIPE_SUB_OVF_EN.
- Defined:
  - Adds output port Ov (1 bit), registered alongside Df/Bo.
  - Ov=1 iff the signed two's-complement result A - B - Bi overflows WIDTH bits, i.e. A[MSB]!=B[MSB] and Df[MSB]!=A[MSB].
  - Ov resets to 0 and holds under stall like Df.
- Undefined: port Ov and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, CHUNK=4. A=0x35, B=0x12, Bi=0, single transfer -> Df=0x23, Bo=0, out_valid visible 2 cycles after the accept edge.
- A=0x12, B=0x35, Bi=0 -> Df=0xDD, Bo=1. Then A=0x00, B=0x00, Bi=1 -> Df=0xFF, Bo=1.
- Back-to-back inputs 0x10-0x01, 0x20-0x02, 0x30-0x03 with out_ready=1 -> Df 0x0F, 0x1E, 0x2D on consecutive cycles, Bo=0.
- Same stream, out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, Df held at 0x0F, then all three results delivered in order, none lost.
- rst_n=0 for one edge with two tokens in flight -> out_valid=0 next cycle, Df=0, Bo=0, no stale results afterwards.
- HS_PIPE_SUB_OVF_EN defined: A=0x80, B=0x01, Bi=0 -> Df=0x7F, Bo=0, Ov=1. A=0x05, B=0x03 -> Df=0x02, Ov=0.
